sample_buffer: RTL
==================

SAMPLE_BUFFER -- requirements
Module: sample_buffer

Interface
REQ-001 SHALL have parameter DSIZE, default 32: sample width in bits.
REQ-002 SHALL have parameter AW, default 10: address width; memory depth 2^AW.
REQ-003 SHALL have port clk, input, 1: single clock for all logic and memory.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port s_tdata, input, DSIZE: sample from capture stage.
REQ-006 SHALL have port s_tvalid, input, 1: sample valid.
REQ-007 SHALL have port s_tready, output, 1: buffer accepting samples.
REQ-008 SHALL have port start, input, 1: begin new fill.
REQ-009 SHALL have port cap_done, input, 1: capture complete; begin readout.
REQ-010 SHALL have port abort, input, 1: cancel any operation.
REQ-011 SHALL have port buffer_size, input, AW+1: ring length in samples.
REQ-012 SHALL have port m_tdata, output, DSIZE: readout sample.
REQ-013 SHALL have port m_tvalid, output, 1: readout valid.
REQ-014 SHALL have port m_tready, input, 1: downstream ready.
REQ-015 SHALL have port m_tlast, output, 1: final readout beat.
REQ-016 SHALL have port busy, output, 1: state != IDLE.
REQ-017 SHALL have port rd_done, output, 1: one-cycle pulse after last readout beat.

Function
REQ-018 SHALL implement states IDLE, FILL, READ.
REQ-019 SHALL clamp effective length L: buffer_size 0 or > 2^AW -> 2^AW; sampled on start.
REQ-020 IDLE: start -> FILL; wr_ptr=0, count=0, wrapped=0; start ignored in other states.
REQ-021 SHALL drive s_tready=1 only in FILL; 0 otherwise, including reset.
REQ-022 FILL: each s_tvalid&&s_tready cycle SHALL write mem[wr_ptr]; wr_ptr increments, wraps L-1 -> 0 and sets wrapped.
REQ-023 count SHALL increment per beat, saturating at L.
REQ-024 FILL: cap_done -> READ; beat in same cycle as cap_done SHALL be written and counted.
REQ-025 READ start address SHALL be wr_ptr if wrapped else 0; SHALL emit count beats in write order, oldest first, address wrapping at L-1 -> 0.
REQ-026 cap_done with count=0 SHALL go IDLE with rd_done pulse, no beats.
REQ-027 Memory read latency 1 cycle; output SHALL use skid/holding register so m_tdata/m_tvalid stay stable while m_tvalid&&!m_tready.
REQ-028 SHALL sustain one beat per cycle when m_tready held high; first m_tvalid no later than 2 cycles after READ entry.
REQ-029 m_tlast SHALL assert with final beat only.
REQ-030 After final handshake -> IDLE next cycle; rd_done=1 for that one cycle.
REQ-031 abort SHALL force IDLE next cycle, drop m_tvalid, no rd_done; abort wins over simultaneous start/cap_done.

Reset
REQ-032 Reset SHALL set state IDLE, s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, rd_done=0, pointers/count/wrapped=0.
REQ-033 Reset mid-FILL or mid-READ SHALL discard operation; memory contents undefined, not cleared.

Configuration
REQ-034 With SBUF_TLAST_EN defined, m_tlast SHALL behave per REQ-029; without it, m_tlast SHALL be constant 0 and rd_done remains functional.

Verification
REQ-035 L=8, start, 5 beats 0..4, cap_done -> readout 0,1,2,3,4, m_tlast on 4, rd_done pulse.
REQ-036 L=8, 11 beats 0..10, cap_done -> readout 3..10 (8 beats), m_tlast on 10.
REQ-037 L=4, m_tready toggled 1/0 each cycle -> 4 beats, data held stable across stalls, no loss/duplication.
REQ-038 buffer_size=0, AW=4, 20 beats -> readout 4..19 (16 beats).
REQ-039 abort mid-READ after 2 beats -> m_tvalid=0 next cycle, busy=0, no rd_done; new start accepted.
REQ-040 cap_done with same-cycle beat 0x55 as 3rd sample, L=8 -> 3 beats, last = 0x55.

Source files
------------

// File: rtl/sample_buffer.sv
// sample_buffer: ring-buffered sample capture with in-order streamed readout, oldest sample first.
// Define SBUF_TLAST_EN to drive m_tlast on the final readout beat; otherwise m_tlast is tied low.
module sample_buffer #(
    parameter int DSIZE = 32,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DSIZE-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             start,
    input  logic             cap_done,
    input  logic             abort,
    input  logic [AW:0]      buffer_size,
    output logic [DSIZE-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic             busy,
    output logic             rd_done
);
    localparam logic [1:0]  IDLE  = 2'd0;
    localparam logic [1:0]  FILL  = 2'd1;
    localparam logic [1:0]  READ  = 2'd2;
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE   = (AW+1)'(1);

    logic [1:0]       state;
    logic [AW:0]      len;
    logic [AW:0]      count;
    logic [AW:0]      issue_cnt;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_addr;
    logic             wrapped;

    logic [DSIZE-1:0] mem [0:(1<<AW)-1];
    logic [DSIZE-1:0] rd_data;
    logic             pipe_valid;
    logic             pipe_last;
    logic [DSIZE-1:0] skid_data;
    logic             skid_valid;
    logic             skid_last;
    logic             out_last;

    logic             wr_beat;
    logic             wr_at_end;
    logic             rd_at_end;
    logic             out_fire;
    logic             out_free;
    logic             rd_issue;
    logic             final_fire;
    logic [1:0]       occ;
    logic [AW-1:0]    wr_ptr_nxt;
    logic             wrapped_nxt;
    logic [AW:0]      count_nxt;

    assign s_tready   = (state == FILL);
    assign busy       = (state != IDLE);
    assign wr_beat    = s_tvalid && s_tready;
    assign wr_at_end  = ({1'b0, wr_ptr} == len - ONE);
    assign rd_at_end  = ({1'b0, rd_addr} == len - ONE);
    assign out_fire   = m_tvalid && m_tready;
    assign out_free   = !m_tvalid || m_tready;
    assign final_fire = out_fire && out_last;

    // Only fetch when the word can land next cycle even if the sink stalls: output + skid hold two.
    assign occ      = 2'(m_tvalid) + 2'(skid_valid) + 2'(pipe_valid) - 2'(out_fire);
    assign rd_issue = (state == READ) && (issue_cnt != '0) && (occ <= 2'd1);

    // Write-side values including a beat taken this cycle, so cap_done sees it.
    always_comb begin
        wr_ptr_nxt  = wr_ptr;
        wrapped_nxt = wrapped;
        count_nxt   = count;
        if (wr_beat) begin
            wr_ptr_nxt  = wr_at_end ? '0 : wr_ptr + AW'(1);
            wrapped_nxt = wrapped | wr_at_end;
            count_nxt   = (count == len) ? count : count + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            len       <= DEPTH;
            wr_ptr    <= '0;
            wrapped   <= 1'b0;
            count     <= '0;
            rd_addr   <= '0;
            issue_cnt <= '0;
            rd_done   <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state   <= FILL;
                        len     <= (buffer_size == '0 || buffer_size > DEPTH) ? DEPTH : buffer_size;
                        wr_ptr  <= '0;
                        wrapped <= 1'b0;
                        count   <= '0;
                    end
                    FILL: begin
                        wr_ptr  <= wr_ptr_nxt;
                        wrapped <= wrapped_nxt;
                        count   <= count_nxt;
                        if (cap_done) begin
                            if (count_nxt == '0) begin
                                state   <= IDLE;
                                rd_done <= 1'b1;
                            end else begin
                                state     <= READ;
                                issue_cnt <= count_nxt;
                                rd_addr   <= wrapped_nxt ? wr_ptr_nxt : '0;
                            end
                        end
                    end
                    READ: begin
                        if (rd_issue) begin
                            issue_cnt <= issue_cnt - ONE;
                            rd_addr   <= rd_at_end ? '0 : rd_addr + AW'(1);
                        end
                        if (final_fire) begin
                            state   <= IDLE;
                            rd_done <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // NOTE: the sample memory is deliberately not reset; clearing it would need a write port per word.
    always_ff @(posedge clk) begin
        if (wr_beat) mem[wr_ptr] <= s_tdata;
        if (rd_issue) rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            pipe_valid <= 1'b0;
            pipe_last  <= 1'b0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
            skid_data  <= '0;
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            out_last   <= 1'b0;
        end else begin
            pipe_valid <= rd_issue;
            if (rd_issue) pipe_last <= (issue_cnt == ONE);
            if (out_free) begin
                if (skid_valid) begin
                    m_tvalid   <= 1'b1;
                    m_tdata    <= skid_data;
                    out_last   <= skid_last;
                    skid_valid <= pipe_valid;
                    skid_data  <= rd_data;
                    skid_last  <= pipe_last;
                end else begin
                    m_tvalid <= pipe_valid;
                    out_last <= pipe_valid && pipe_last;
                    if (pipe_valid) m_tdata <= rd_data;
                end
            end else if (pipe_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= rd_data;
                skid_last  <= pipe_last;
            end
        end
    end

`ifdef SBUF_TLAST_EN
    assign m_tlast = out_last;
`else
    assign m_tlast = 1'b0;
`endif

endmodule
